// File: rtl/envelope_column_renderer.sv
// ============================================================================
// envelope_column_renderer
// ----------------------------------------------------------------------------
// Walks the per-interval (max, min) envelope tables and turns each entry into
// one vertical bitmap column for the waveform display path.
//
// For each interval the block:
//   1. issues a one-cycle table read
//   2. captures the returned pair
//   3. maps both values to pixel rows
//   4. holds the column on a valid/ready port until it is accepted
//
// A pass is started by a single start pulse. Completion is signalled by a
// one-cycle done pulse.
//
// Optional build macro:
//   ENV_RENDER_FILL_EN
//     - defined   : every row between row(min) and row(max), inclusive, is set
//                   (filled bar)
//     - undefined : only row(min) and row(max) are set (outline)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset; also aborts a pass in flight
//   start      begin a render pass (sampled in IDLE only)
//   num_cols   columns to render, sampled with start; clipped to NUM_INTERVALS
//   busy       high while a pass is in progress, including the done cycle
//   done       one-cycle pulse at the end of a pass
//   rd_en      table read strobe (one cycle per interval)
//   rd_addr    interval index being read
//   rd_max     signed max entry; valid the cycle after rd_en
//   rd_min     signed min entry; valid the cycle after rd_en
//   col_valid  column data valid
//   col_ready  sink accepts the column
//   col_data   bitmap; bit r = pixel row r, with row 0 = most negative level
//   col_index  interval index of col_data
//   col_last   marks the final column of the pass
// ============================================================================
module envelope_column_renderer #(
    parameter int NUM_INTERVALS = 10,
    parameter int SAMPLE_W      = 32,
    parameter int ROWS          = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [15:0]                num_cols,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_en,
    output logic [15:0]                rd_addr,
    input  logic signed [SAMPLE_W-1:0] rd_max,
    input  logic signed [SAMPLE_W-1:0] rd_min,
    output logic                       col_valid,
    input  logic                       col_ready,
    output logic [ROWS-1:0]            col_data,
    output logic [15:0]                col_index,
    output logic                       col_last
);

    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SCALE,
        S_EMIT,
        S_FIN
    } state_t;

    state_t state_reg, state_next;

    logic [15:0] n_reg, n_next;
    logic [15:0] idx_reg, idx_next;
    logic [15:0] clip_n;

    // Only the top ROW_W bits of each entry select a row, so only those are
    // captured.
    logic [ROW_W-1:0] max_top_reg, min_top_reg;
    logic [ROW_W-1:0] row_max, row_min, row_lo, row_hi;
    logic [ROWS-1:0]  col_data_next;

    logic             col_valid_reg;
    logic [ROWS-1:0]  col_data_reg;
    logic [15:0]      col_index_reg;
    logic             col_last_reg;

    logic             handshake;

    // Entry bits below the row resolution have no effect on the column.
    logic unused_sample_bits;
    assign unused_sample_bits = ^{rd_max, rd_min};

    assign clip_n = (num_cols > 16'(NUM_INTERVALS)) ? 16'(NUM_INTERVALS)
                                                    : num_cols;
    assign handshake = col_valid_reg && col_ready;

    // ------------------------------------------------------------------
    // FSM state and pass counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            n_reg     <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    n_next     = clip_n;
                    idx_next   = '0;
                    // An empty pass still reports completion, without reads.
                    state_next = (clip_n == 16'd0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT:  state_next = S_SCALE;
            S_SCALE: state_next = S_EMIT;
            S_EMIT: begin
                if (handshake) begin
                    if (col_last_reg) begin
                        state_next = S_FIN;
                    end else begin
                        idx_next   = idx_reg + 16'd1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_FIN);
    assign rd_en   = (state_reg == S_FETCH);
    assign rd_addr = idx_reg;

    // ------------------------------------------------------------------
    // Row mapping: the top ROW_W bits with the sign bit inverted give
    // offset binary, so the most negative value lands on row 0.
    // ------------------------------------------------------------------
    function automatic logic [ROW_W-1:0] to_row(input logic [ROW_W-1:0] top);
        to_row = top ^ (ROW_W'(1) << (ROW_W - 1));
    endfunction

    assign row_max = to_row(max_top_reg);
    assign row_min = to_row(min_top_reg);

    // A corrupt entry with min above max is rendered with the rows swapped.
    assign row_lo = (row_min > row_max) ? row_max : row_min;
    assign row_hi = (row_min > row_max) ? row_min : row_max;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_col_bit
            localparam logic [ROW_W-1:0] ROW_ID = ROW_W'(gi);
`ifdef ENV_RENDER_FILL_EN
            assign col_data_next[gi] = (ROW_ID >= row_lo) && (ROW_ID <= row_hi);
`else
            assign col_data_next[gi] = (ROW_ID == row_lo) || (ROW_ID == row_hi);
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath: entry capture and the held column output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            max_top_reg   <= '0;
            min_top_reg   <= '0;
            col_valid_reg <= 1'b0;
            col_data_reg  <= '0;
            col_index_reg <= '0;
            col_last_reg  <= 1'b0;
        end else begin
            if (state_reg == S_WAIT) begin
                max_top_reg <= rd_max[SAMPLE_W-1 -: ROW_W];
                min_top_reg <= rd_min[SAMPLE_W-1 -: ROW_W];
            end
            if (state_reg == S_SCALE) begin
                col_data_reg  <= col_data_next;
                col_index_reg <= idx_reg;
                col_last_reg  <= (idx_reg == n_reg - 16'd1);
                col_valid_reg <= 1'b1;
            end else if ((state_reg == S_EMIT) && handshake) begin
                col_valid_reg <= 1'b0;
            end
        end
    end

    assign col_valid = col_valid_reg;
    assign col_data  = col_data_reg;
    assign col_index = col_index_reg;
    assign col_last  = col_last_reg;

endmodule

// File: tb/tb_envelope_column_renderer.sv
module tb_envelope_column_renderer;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [15:0]        num_cols;
    logic               busy, done, rd_en;
    logic [15:0]        rd_addr;
    logic signed [31:0] rd_max, rd_min;
    logic               col_valid, col_ready;
    logic [63:0]        col_data;
    logic [15:0]        col_index;
    logic               col_last;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_max [16];
    logic [31:0] mem_min [16];

    envelope_column_renderer #(
        .NUM_INTERVALS(10),
        .SAMPLE_W(32),
        .ROWS(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_cols(num_cols),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_max(rd_max),
        .rd_min(rd_min),
        .col_valid(col_valid),
        .col_ready(col_ready),
        .col_data(col_data),
        .col_index(col_index),
        .col_last(col_last)
    );

    always #5 clk = ~clk;

    // Synchronous table: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_max <= mem_max[rd_addr[3:0]];
            rd_min <= mem_min[rd_addr[3:0]];
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Entry i: max = i*2^26 -> row 32+i, min = -i*2^26 -> row 32-i.
    task automatic load_table();
        for (int i = 0; i < 16; i++) begin
            mem_max[i] = 32'(i << 26);
            mem_min[i] = 32'(-(i << 26));
        end
    endtask

    function automatic logic [63:0] exp_bits(input int lo, input int hi);
        logic [63:0] v;
        v = '0;
`ifdef ENV_RENDER_FILL_EN
        for (int r = lo; r <= hi; r++) v[r] = 1'b1;
`else
        v[lo] = 1'b1;
        v[hi] = 1'b1;
`endif
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; num_cols = '0; col_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, rd_en, rd_addr, col_valid, col_data, col_index, col_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b rd_addr=%0d col_valid=%b col_data=%h col_index=%0d col_last=%b, all required 0",
                     busy, done, rd_en, rd_addr, col_valid, col_data, col_index, col_last);
        end
        reset = 1'b0;
        tick();
        $display("test_reset: outputs at reset values checked");
    endtask

    task automatic test_basic();
        int lat;
        mem_max[0] = 32'h4000_0000;
        mem_min[0] = 32'hC000_0000;
        num_cols = 16'd1; col_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; lat = 1;
        while (!col_valid && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d cycles, required 4", lat); end
        checks++;
        if (col_data !== exp_bits(16, 48)) begin errors++; $display("FAIL basic_data: got %h, required %h", col_data, exp_bits(16, 48)); end
        checks++;
        if (col_last !== 1'b1 || col_index !== 16'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_flags: col_last=%b col_index=%0d busy=%b, required 1 0 1", col_last, col_index, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || col_valid !== 1'b0) begin errors++; $display("FAIL basic_done: done=%b col_valid=%b, required 1 0", done, col_valid); end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_width: done=%b busy=%b, required 0 0", done, busy); end
        $display("test_basic: col_data=%h latency=%0d", col_data, lat);
    endtask

    task automatic test_full_table();
        int nrd, ncol, first, lastc, donec, cyc;
        logic exp_last;
        load_table();
        num_cols = 16'd20; col_ready = 1'b1;
        nrd = 0; ncol = 0; first = -1; lastc = -1; donec = -1;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (donec < 0 && cyc < 100) begin
            if (rd_en) begin
                checks++;
                if (rd_addr !== 16'(nrd)) begin errors++; $display("FAIL full_rd_addr: got %0d, required %0d", rd_addr, nrd); end
                nrd++;
            end
            if (col_valid) begin
                exp_last = (ncol == 9);
                checks++;
                if (col_index !== 16'(ncol) || col_last !== exp_last || col_data !== exp_bits(32 - ncol, 32 + ncol)) begin
                    errors++;
                    $display("FAIL full_column: index=%0d last=%b data=%h, required index=%0d last=%b data=%h",
                             col_index, col_last, col_data, ncol, exp_last, exp_bits(32 - ncol, 32 + ncol));
                end
                if (first < 0) first = cyc;
                lastc = cyc;
                ncol++;
            end
            if (done) donec = cyc;
            tick(); cyc++;
        end
        checks++;
        if (nrd !== 10 || ncol !== 10) begin errors++; $display("FAIL full_counts: reads=%0d cols=%0d, required 10 10", nrd, ncol); end
        checks++;
        if (first !== 4 || lastc !== 40 || donec !== 41) begin
            errors++; $display("FAIL full_timing: first=%0d last=%0d done=%0d, required 4 40 41", first, lastc, donec);
        end
        $display("test_full_table: reads=%0d cols=%0d first=%0d last=%0d done=%0d", nrd, ncol, first, lastc, donec);
    endtask

    task automatic test_backpressure();
        int cyc;
        bit seen_done;
        load_table();
        num_cols = 16'd4; col_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (!(col_valid && col_index == 16'd2) && cyc < 40) begin tick(); cyc++; end
        checks++;
        if (!(col_valid && col_index == 16'd2)) begin errors++; $display("FAIL bp_reach_col2: col_valid=%b index=%0d, required 1 2", col_valid, col_index); end
        col_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (col_valid !== 1'b1 || col_index !== 16'd2 || col_data !== exp_bits(30, 34) || rd_en !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: valid=%b index=%0d data=%h rd_en=%b, required 1 2 %h 0",
                         col_valid, col_index, col_data, rd_en, exp_bits(30, 34));
            end
        end
        col_ready = 1'b1;
        tick();
        checks++;
        if (col_valid !== 1'b0 || rd_en !== 1'b1 || rd_addr !== 16'd3) begin
            errors++; $display("FAIL bp_release: valid=%b rd_en=%b rd_addr=%0d, required 0 1 3", col_valid, rd_en, rd_addr);
        end
        seen_done = 1'b0; cyc = 0;
        while (!seen_done && cyc < 40) begin if (done) seen_done = 1'b1; tick(); cyc++; end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL bp_done: no done within 40 cycles, required done"); end
        $display("test_backpressure: column 2 held 7 cycles");
    endtask

    task automatic test_extremes();
        int ncol, cyc;
        bit seen_done;
        mem_max[0] = 32'h7FFF_FFFF; mem_min[0] = 32'h8000_0000;
        mem_max[1] = 32'h8000_0000; mem_min[1] = 32'h7FFF_FFFF;
        num_cols = 16'd2; col_ready = 1'b1;
        ncol = 0; seen_done = 1'b0;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (!seen_done && cyc < 40) begin
            if (col_valid) begin
                checks++;
                if (col_data !== exp_bits(0, 63)) begin
                    errors++; $display("FAIL extreme_col%0d: got %h, required %h", ncol, col_data, exp_bits(0, 63));
                end
                ncol++;
            end
            if (done) seen_done = 1'b1;
            tick(); cyc++;
        end
        checks++;
        if (ncol !== 2 || !seen_done) begin errors++; $display("FAIL extreme_count: cols=%0d done=%b, required 2 1", ncol, seen_done); end
        $display("test_extremes: cols=%0d", ncol);
    endtask

    task automatic test_zero_and_ignored_start();
        int nrd, nval, ndone, ncol;
        num_cols = 16'd0; col_ready = 1'b1;
        nrd = 0; nval = 0; ndone = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rd_en) nrd++;
            if (col_valid) nval++;
            if (done) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 1 || nrd !== 0 || nval !== 0) begin
            errors++; $display("FAIL zero_len: done=%0d rd_en=%0d col_valid=%0d, required 1 0 0", ndone, nrd, nval);
        end
        load_table();
        num_cols = 16'd2; ndone = 0; ncol = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 30; c++) begin
            if (col_valid && col_ready) ncol++;
            if (done) ndone++;
            start = (c == 3 || c == 7);
            num_cols = (c == 3 || c == 7) ? 16'd9 : 16'd2;
            tick();
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || ncol !== 2) begin
            errors++; $display("FAIL ignored_start: done=%0d cols=%0d, required 1 2", ndone, ncol);
        end
        $display("test_zero_and_ignored_start: done pulses=%0d cols=%0d", ndone, ncol);
    endtask

    task automatic test_reset_midpass();
        int cyc, ndone;
        load_table();
        num_cols = 16'd10; col_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0; cyc = 1;
        while (!(col_valid && col_index == 16'd3) && cyc < 60) begin tick(); cyc++; end
        checks++;
        if (!(col_valid && col_index == 16'd3)) begin errors++; $display("FAIL rst_reach_col3: valid=%b index=%0d, required 1 3", col_valid, col_index); end
        col_ready = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if ({busy, done, rd_en, rd_addr, col_valid, col_data, col_index, col_last} !== '0) begin
            errors++;
            $display("FAIL rst_midpass_outputs: busy=%b done=%b rd_en=%b rd_addr=%0d col_valid=%b col_data=%h col_index=%0d col_last=%b, all required 0",
                     busy, done, rd_en, rd_addr, col_valid, col_data, col_index, col_last);
        end
        reset = 1'b0; ndone = 0;
        for (int c = 0; c < 6; c++) begin if (done) ndone++; tick(); end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL rst_no_done: done pulses=%0d, required 0", ndone); end
        num_cols = 16'd1; col_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== 16'd0) begin errors++; $display("FAIL rst_restart_read: rd_en=%b rd_addr=%0d, required 1 0", rd_en, rd_addr); end
        tick(); tick(); tick();
        checks++;
        if (col_valid !== 1'b1 || col_index !== 16'd0 || col_data !== exp_bits(32, 32)) begin
            errors++; $display("FAIL rst_restart_col: valid=%b index=%0d data=%h, required 1 0 %h", col_valid, col_index, col_data, exp_bits(32, 32));
        end
        tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL rst_restart_done: done=%b, required 1", done); end
        tick();
        $display("test_reset_midpass: restart rendered index 0");
    endtask

    initial begin
        rd_max = '0; rd_min = '0;
        for (int i = 0; i < 16; i++) begin mem_max[i] = '0; mem_min[i] = '0; end
        test_reset();
        test_basic();
        test_full_table();
        test_backpressure();
        test_extremes();
        test_zero_and_ignored_start();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
